// File: rtl/sriz_seq.sv
// Multi-cycle core sequencer: fetch / execute / memory phases with a per-phase
// wait timeout, a sticky halt state and free-running cycle/retire counters.
module sriz_seq #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req,
  input  logic             ifu_valid,
  output logic             inst_latch,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_ebreak,
  input  logic             regen,
  output logic             lsu_req,
  output logic             lsu_wen,
  input  logic             lsu_valid,
  output logic             pc_wen,
  output logic             reg_wen,
  output logic             halt,
  output logic             err,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);

  // Handshake: ifu_req / lsu_req stay high until the matching valid is seen in
  // the same cycle; a valid while its request is low is ignored.
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               store_q, store_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cycles_q, retired_q;
  logic               timeout;

  assign timeout = (wait_q == WAIT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      store_q   <= 1'b0;
      err_q     <= 1'b0;
      cycles_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      store_q <= store_d;
      err_q   <= err_d;
      if (state_q != HALT) cycles_q <= cycles_q + CNT_W'(1);
      if (pc_wen) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // The wait counter only survives cycles spent waiting; any exit clears it,
  // so it is already zero on every entry to FETCH or MEM.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    store_d = store_q;
    err_d   = err_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (ifu_valid) begin
          state_d = EXEC;
        end else if (timeout) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      EXEC: begin
        if (is_ebreak) begin
          state_d = HALT;
        end else if (is_load && is_store) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else if (is_load || is_store) begin
          state_d = MEM;
          store_d = is_store;
        end else begin
          state_d = FETCH;
        end
      end
      MEM: begin
        if (lsu_valid) begin
          state_d = FETCH;
        end else if (timeout) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Every output is forced low while rst is high, Mealy strobes included.
  always_comb begin
    ifu_req    = 1'b0;
    inst_latch = 1'b0;
    lsu_req    = 1'b0;
    lsu_wen    = 1'b0;
    pc_wen     = 1'b0;
    reg_wen    = 1'b0;
    halt       = 1'b0;
    err        = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          ifu_req    = 1'b1;
          inst_latch = ifu_valid;
        end
        EXEC: begin
          if (!is_ebreak && !is_load && !is_store) begin
            pc_wen  = 1'b1;
            reg_wen = regen;
          end
        end
        MEM: begin
          lsu_req = 1'b1;
          lsu_wen = store_q;
          if (lsu_valid) begin
            pc_wen  = 1'b1;
            reg_wen = regen & ~store_q;
          end
        end
        HALT: begin
          halt = 1'b1;
          err  = err_q;
        end
        default: ;
      endcase
    end
  end

  assign cycles    = rst ? '0 : cycles_q;
  assign retired   = rst ? '0 : retired_q;
  assign state_dbg = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_sriz_seq.sv
// Bench for sriz_seq: open-loop instruction driver with an instruction-level
// timing model feeding a scoreboard; a monitor checks every retire/halt event.
module tb_sriz_seq;

  localparam int CW = 32;
  localparam int TO = 4;
  localparam int W  = 101;

  localparam int K_ALU     = 0;
  localparam int K_MEM     = 1;
  localparam int K_EBREAK  = 2;
  localparam int K_ILLEGAL = 3;
  localparam int K_FTO     = 4;
  localparam int K_MTO     = 5;
  localparam int K_RST_MEM = 6;
  localparam int K_RST_FET = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req, ifu_valid, inst_latch;
  logic          is_load, is_store, is_ebreak, regen;
  logic          lsu_req, lsu_wen, lsu_valid;
  logic          pc_wen, reg_wen, halt, err;
  logic [CW-1:0] cycles, retired;
  logic [2:0]    state_dbg;

  sriz_seq #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_valid(ifu_valid), .inst_latch(inst_latch),
    .is_load(is_load), .is_store(is_store), .is_ebreak(is_ebreak), .regen(regen),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_valid(lsu_valid),
    .pc_wen(pc_wen), .reg_wen(reg_wen), .halt(halt), .err(err),
    .cycles(cycles), .retired(retired), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // model: cycle index of the current instruction's first fetch, retired count
  int s_cyc;
  int ret_cnt;

  // Event record: kind(halt) err reg_wen lsu_req lsu_wen | fetch cycles, mem
  // cycles, store cycles, latch pulses, stray reg_wen | cycles, retired
  function automatic logic [W-1:0] mk(bit hk, bit er, bit rw, bit lr, bit lw,
      int ifn, int lsn, int wn, int ln, int sn, int cyc, int rt);
    return {hk, er, rw, lr, lw, 8'(ifn), 8'(lsn), 8'(wn), 4'(ln), 4'(sn),
            CW'(cyc), CW'(rt)};
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(bit ifv, bit lsv, bit ld, bit st, bit eb, bit rg);
    ifu_valid = ifv;
    lsu_valid = lsv;
    is_load   = ld;
    is_store  = st;
    is_ebreak = eb;
    regen     = rg;
    @(posedge clk);
    #1;
  endtask

  task automatic junk(bit ifv, bit lsv);
    cyc(ifv, lsv, rb(), rb(), rb(), rb());
  endtask

  // Reset with every valid/enable high: the Mealy strobes must stay low.
  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) begin
      rst       = 1'b1;
      ifu_valid = 1'b1;
      lsu_valid = 1'b1;
      is_load   = rb();
      is_store  = rb();
      is_ebreak = rb();
      regen     = 1'b1;
      @(negedge clk);
      chk("rst_outputs", {ifu_req, inst_latch, lsu_req, lsu_wen, pc_wen, reg_wen,
          halt, err, state_dbg, cycles, retired}, '0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    ifu_valid = rb();
    lsu_valid = rb();
    @(negedge clk);
    chk("idle_after_rst", {ifu_req, halt, lsu_req, cycles, retired}, '0);
    @(posedge clk);
    #1;
    s_cyc   = 1;
    ret_cnt = 0;
  endtask

  task automatic hold_halt(bit er, int hc);
    for (int i = 0; i < 3; i++) begin
      ifu_valid = rb();
      lsu_valid = rb();
      is_load   = rb();
      is_store  = rb();
      is_ebreak = rb();
      regen     = rb();
      @(negedge clk);
      chk("halt_hold", {halt, err, ifu_req, inst_latch, lsu_req, lsu_wen, pc_wen,
          reg_wen, cycles, retired}, {1'b1, er, 6'b0, CW'(hc), CW'(ret_cnt)});
      @(posedge clk);
      #1;
    end
  endtask

  // One instruction: fd fetch wait cycles, md memory wait cycles.
  task automatic run_instr(int kind, int fd, int md, bit rg, bit st);
    case (kind)
      K_ALU:     exp_q.push_back(mk(0, 0, rg, 0, 0, fd + 1, 0, 0, 1, 0, s_cyc + fd + 1, ret_cnt));
      K_MEM:     exp_q.push_back(mk(0, 0, rg && !st, 1, st, fd + 1, md + 1, st ? md + 1 : 0, 1, 0,
                                    s_cyc + fd + 2 + md, ret_cnt));
      K_EBREAK:  exp_q.push_back(mk(1, 0, 0, 0, 0, fd + 1, 0, 0, 1, 0, s_cyc + fd + 2, ret_cnt));
      K_ILLEGAL: exp_q.push_back(mk(1, 1, 0, 0, 0, fd + 1, 0, 0, 1, 0, s_cyc + fd + 2, ret_cnt));
      K_FTO:     exp_q.push_back(mk(1, 1, 0, 0, 0, TO + 1, 0, 0, 0, 0, s_cyc + TO + 1, ret_cnt));
      K_MTO:     exp_q.push_back(mk(1, 1, 0, 0, 0, fd + 1, TO + 1, st ? TO + 1 : 0, 1, 0,
                                    s_cyc + fd + 3 + TO, ret_cnt));
      default: ;
    endcase
    if (kind == K_FTO) begin
      for (int i = 0; i <= TO; i++) junk(1'b0, rb());
      hold_halt(1'b1, s_cyc + TO + 1);
      return;
    end
    for (int i = 0; i < fd; i++) junk(1'b0, rb());
    if (kind == K_RST_FET) return;
    junk(1'b1, rb());
    case (kind)
      K_ALU:     cyc(rb(), rb(), 1'b0, 1'b0, 1'b0, rg);
      K_EBREAK:  cyc(rb(), rb(), rb(), rb(), 1'b1, rb());
      K_ILLEGAL: cyc(rb(), rb(), 1'b1, 1'b1, 1'b0, rb());
      default:   cyc(rb(), rb(), !st, st, 1'b0, rb());
    endcase
    case (kind)
      K_ALU: begin
        s_cyc += fd + 2;
        ret_cnt++;
      end
      K_MEM: begin
        for (int i = 0; i < md; i++) junk(rb(), 1'b0);
        cyc(rb(), 1'b1, rb(), rb(), rb(), rg);
        s_cyc += fd + md + 3;
        ret_cnt++;
      end
      K_EBREAK:  hold_halt(1'b0, s_cyc + fd + 2);
      K_ILLEGAL: hold_halt(1'b1, s_cyc + fd + 2);
      K_MTO: begin
        for (int i = 0; i <= TO; i++) junk(rb(), 1'b0);
        hold_halt(1'b1, s_cyc + fd + 3 + TO);
      end
      K_RST_MEM: for (int i = 0; i < md; i++) junk(rb(), 1'b0);
      default: ;
    endcase
  endtask

  // ---------------- monitor / scoreboard ----------------
  int ifu_n, lsu_n, wen_n, lat_n, stray_n;
  bit halt_prev;
  logic [W-1:0] mon_act, mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      ifu_n = 0; lsu_n = 0; wen_n = 0; lat_n = 0; stray_n = 0;
      halt_prev = 1'b0;
    end else begin
      if (ifu_req) ifu_n++;
      if (lsu_req) lsu_n++;
      if (lsu_req && lsu_wen) wen_n++;
      if (inst_latch) lat_n++;
      if (reg_wen && !pc_wen) stray_n++;
      if (pc_wen || (halt && !halt_prev)) begin
        mon_act = mk(halt, err, reg_wen, lsu_req, lsu_wen, ifu_n, lsu_n, wen_n,
                     lat_n, stray_n, int'(cycles), int'(retired));
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event_unexpected: got %h expected none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL event: got %h expected %h", mon_act, mon_exp);
          end
        end
        ifu_n = 0; lsu_n = 0; wen_n = 0; lat_n = 0; stray_n = 0;
      end
      halt_prev = halt;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    is_load = 1'b0; is_store = 1'b0; is_ebreak = 1'b0; regen = 1'b0;
    s_cyc = 1; ret_cnt = 0;

    // back-to-back ALU ops with instant fetch
    do_reset(2);
    for (int i = 0; i < 6; i++) run_instr(K_ALU, 0, 0, 1'b1, 1'b0);
    // load, then store with regen=1, each 3 cycles of lsu_req
    do_reset(1);
    run_instr(K_MEM, 0, 2, 1'b1, 1'b0);
    run_instr(K_ALU, 0, 0, 1'b1, 1'b0);
    run_instr(K_MEM, 1, 2, 1'b1, 1'b1);
    run_instr(K_ALU, 0, 0, 1'b0, 1'b0);
    // fetch timeout, then valid arriving in the last allowed cycle
    do_reset(1);
    run_instr(K_FTO, 0, 0, 1'b0, 1'b0);
    do_reset(1);
    run_instr(K_ALU, TO, 0, 1'b1, 1'b0);
    run_instr(K_MEM, 0, TO, 1'b1, 1'b0);
    run_instr(K_EBREAK, 0, 0, 1'b0, 1'b0);
    do_reset(1);
    run_instr(K_ALU, 2, 0, 1'b1, 1'b0);
    run_instr(K_ILLEGAL, 0, 0, 1'b0, 1'b0);
    do_reset(1);
    run_instr(K_RST_MEM, 0, 2, 1'b1, 1'b0);
    do_reset(1);
    run_instr(K_MTO, 1, 0, 1'b0, 1'b1);

    // random episodes
    for (int ep = 0; ep < 40; ep++) begin
      int n;
      int last;
      do_reset($urandom_range(1, 2));
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        if (rb()) run_instr(K_ALU, $urandom_range(0, TO), 0, rb(), 1'b0);
        else      run_instr(K_MEM, $urandom_range(0, TO), $urandom_range(0, TO), rb(), rb());
      end
      last = $urandom_range(1, 7);
      case (last)
        K_RST_MEM: run_instr(K_RST_MEM, $urandom_range(0, TO), $urandom_range(1, TO), rb(), rb());
        K_MEM:     ;
        default:   run_instr(last, $urandom_range(0, TO), 0, rb(), rb());
      endcase
    end
    do_reset(1);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
